// File: rtl/lsu_mem_stage.sv
// Load/store unit for the M pipeline stage.
// This block checks the address of a load or store and raises AdEL/AdES
// when the access is bad. A good access becomes one bus transaction. The
// pipeline is stalled until the bus acknowledges. Load data is then taken
// from the right byte lane and extended to 32 bits.
module lsu_mem_stage #(
    parameter logic [31:0] DM_END  = 32'h0000_2FFF,
    parameter logic [31:0] T0_BASE = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        ld,
    input  logic        st,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic        dm_ov,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall_o,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] rdata_o,
    output logic        rdata_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        ld_r;
    logic        flushed_r;
    logic [1:0]  lo_r;
    logic [1:0]  width_r;
    logic        sext_r;

    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        in_dm;
    logic        in_t0;
    logic        in_t1;
    logic        in_ig;
    logic        in_dev;
    logic        dev_width_bad;
    logic        timer_st8;
    logic        addr_exc;
    logic        req_live;
    logic        accept;

    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [15:0] lane_half;
    logic [7:0]  lane_byte;
    logic [31:0] load_ext;

    // Classify the incoming address. All the checks are ORed together because
    // the exception code depends only on whether the access is a load or a store.
    always_comb begin
        is_word       = width[1];
        is_half       = (width == 2'd1);
        misaligned    = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        in_dm         = (addr <= DM_END);
        in_t0         = (addr >= T0_BASE) && (addr < (T0_BASE + 32'd12));
        in_t1         = (addr >= T1_BASE) && (addr < (T1_BASE + 32'd12));
        in_ig         = (addr >= IG_BASE) && (addr < (IG_BASE + 32'd4));
        in_dev        = in_t0 || in_t1 || in_ig;
        dev_width_bad = in_dev && !is_word;
        timer_st8     = st && ((addr == (T0_BASE + 32'd8)) || (addr == (T1_BASE + 32'd8)));
        addr_exc      = dm_ov || misaligned || (!in_dm && !in_dev) || dev_width_bad || timer_st8;
        req_live      = in_valid && (ld || st);
        accept        = (state == IDLE) && req_live && !flush && !addr_exc;
    end

    // Compute the byte enables and the store data copied across the byte lanes for the request.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (width)
            2'd0: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'd1: begin
                be_next    = 4'b0011 << {addr[1], 1'b0};
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        lane_half = lo_r[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        lane_byte = lo_r[0] ? lane_half[15:8] : lane_half[7:0];
        case (width_r)
            2'd0:    load_ext = sext_r ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
            2'd1:    load_ext = sext_r ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // Compute the next state and the handshake outputs. The outputs are forced low while reset is asserted.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        exc_valid   = 1'b0;
        exc_code    = 5'd0;
        rdata_valid = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (req_live && !flush) begin
                        if (addr_exc) begin
                            exc_valid = 1'b1;
                            exc_code  = ld ? 5'd4 : 5'd5;
                        end else begin
                            stall_o    = 1'b1;
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    stall_o = 1'b1;
                    if (bus_ack) begin
                        state_next = (flushed_r || flush) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    rdata_valid = ld_r && !flush;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load the bus request when an access is accepted. Hold it unchanged until the acknowledge, then drop bus_req.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            ld_r      <= 1'b0;
            lo_r      <= 2'd0;
            width_r   <= 2'd0;
            sext_r    <= 1'b0;
            flushed_r <= 1'b0;
        end else if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= st;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            ld_r      <= ld;
            lo_r      <= addr[1:0];
            width_r   <= width;
            sext_r    <= sign_ext;
            flushed_r <= 1'b0;
        end else if (state == BUSY) begin
            if (flush) begin
                flushed_r <= 1'b1;
            end
            if (bus_ack) begin
                bus_req <= 1'b0;
            end
        end
    end

    // Capture load data on the acknowledge. A flushed load leaves the previous value in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_o <= 32'd0;
        end else if ((state == BUSY) && bus_ack && ld_r && !flushed_r && !flush) begin
            rdata_o <= load_ext;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage. A table of single transactions is applied
// first. Hand-written sequences then cover wait states, flush during BUSY
// and reset during BUSY.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        ld;
    logic        st;
    logic [1:0]  width;
    logic        sign_ext;
    logic [31:0] addr;
    logic        dm_ov;
    logic [31:0] wdata;
    logic        flush;
    logic        stall_o;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] rdata_o;
    logic        rdata_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_vec;
    int n_miss;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  width;
        logic        sext;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic        exp_exc;
        logic [4:0]  exp_code;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    lsu_mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .ld          (ld),
        .st          (st),
        .width       (width),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .dm_ov       (dm_ov),
        .wdata       (wdata),
        .flush       (flush),
        .stall_o     (stall_o),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .rdata_o     (rdata_o),
        .rdata_valid (rdata_valid),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic l, input logic s, input logic [1:0] w, input logic se,
                                input logic [31:0] a, input logic o, input logic [31:0] wd,
                                input logic [31:0] rd, input logic ee, input logic [4:0] ec,
                                input logic [31:0] ea, input logic [3:0] eb,
                                input logic [31:0] ew, input logic [31:0] er);
        vec_t v;
        v.ld = l; v.st = s; v.width = w; v.sext = se; v.addr = a; v.ov = o;
        v.wdata = wd; v.rdata_in = rd; v.exp_exc = ee; v.exp_code = ec;
        v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew; v.exp_rdata = er;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic l, input logic s, input logic [1:0] w, input logic se,
                             input logic [31:0] a, input logic o, input logic [31:0] wd);
        in_valid = 1'b1; ld = l; st = s; width = w; sign_ext = se;
        addr = a; dm_ov = o; wdata = wd;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; ld = 1'b0; st = 1'b0; width = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; dm_ov = 1'b0; wdata = 32'd0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
    endtask

    // Run one table entry. The entry is presented in IDLE. An accepted access gets its acknowledge in the first BUSY cycle.
    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive_req(v.ld, v.st, v.width, v.sext, v.addr, v.ov, v.wdata);
        #1;
        check_output({tag, " exc_valid"}, 32'(exc_valid), 32'(v.exp_exc));
        check_output({tag, " exc_code"}, 32'(exc_code), 32'(v.exp_code));
        check_output({tag, " stall accept"}, 32'(stall_o), 32'(!v.exp_exc));
        if (v.exp_exc) begin
            tick();
            check_output({tag, " no bus_req"}, 32'(bus_req), 32'd0);
            in_valid = 1'b0;
            tick();
        end else begin
            tick();
            check_output({tag, " bus_req"}, 32'(bus_req), 32'd1);
            check_output({tag, " bus_we"}, 32'(bus_we), 32'(v.st));
            check_output({tag, " bus_addr"}, bus_addr, v.exp_addr);
            check_output({tag, " bus_be"}, 32'(bus_be), 32'(v.exp_be));
            check_output({tag, " bus_wdata"}, bus_wdata, v.exp_wdata);
            check_output({tag, " stall busy"}, 32'(stall_o), 32'd1);
            bus_ack = 1'b1;
            bus_rdata = v.rdata_in;
            tick();
            bus_ack = 1'b0;
            bus_rdata = 32'd0;
            #1;
            check_output({tag, " bus_req drop"}, 32'(bus_req), 32'd0);
            check_output({tag, " stall done"}, 32'(stall_o), 32'd0);
            check_output({tag, " rdata_valid"}, 32'(rdata_valid), 32'(v.ld));
            if (v.ld) begin
                check_output({tag, " rdata_o"}, rdata_o, v.exp_rdata);
            end
            in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        idle_inputs();

        vecs[0]  = mk(1,0,2'd0,1,32'h0000_0003,0,32'h0,32'h80FF_FF00,0,5'd0,32'h0000_0000,4'b1000,32'h0,32'hFFFF_FF80);
        vecs[1]  = mk(1,0,2'd0,0,32'h0000_0001,0,32'h0,32'h1122_8344,0,5'd0,32'h0000_0000,4'b0010,32'h0,32'h0000_0083);
        vecs[2]  = mk(1,0,2'd1,1,32'h0000_0002,0,32'h0,32'h9ABC_1234,0,5'd0,32'h0000_0000,4'b1100,32'h0,32'hFFFF_9ABC);
        vecs[3]  = mk(1,0,2'd1,0,32'h0000_0000,0,32'h0,32'h9ABC_F00D,0,5'd0,32'h0000_0000,4'b0011,32'h0,32'h0000_F00D);
        vecs[4]  = mk(1,0,2'd2,0,32'h0000_2FFC,0,32'h0,32'hDEAD_BEEF,0,5'd0,32'h0000_2FFC,4'b1111,32'h0,32'hDEAD_BEEF);
        vecs[5]  = mk(0,1,2'd0,0,32'h0000_0101,0,32'h0000_00A5,32'h0,0,5'd0,32'h0000_0100,4'b0010,32'hA5A5_A5A5,32'h0);
        vecs[6]  = mk(0,1,2'd2,0,32'h0000_7F04,0,32'h1234_5678,32'h0,0,5'd0,32'h0000_7F04,4'b1111,32'h1234_5678,32'h0);
        vecs[7]  = mk(1,0,2'd2,0,32'h0000_7F18,0,32'h0,32'h0000_0055,0,5'd0,32'h0000_7F18,4'b1111,32'h0,32'h0000_0055);
        vecs[8]  = mk(0,1,2'd2,0,32'h0000_7F20,0,32'hFEED_0001,32'h0,0,5'd0,32'h0000_7F20,4'b1111,32'hFEED_0001,32'h0);
        vecs[9]  = mk(1,0,2'd2,0,32'h0000_0006,0,32'h0,32'h0,1,5'd4,32'h0,4'b0,32'h0,32'h0);
        vecs[10] = mk(0,1,2'd2,0,32'h0000_7F08,0,32'h0,32'h0,1,5'd5,32'h0,4'b0,32'h0,32'h0);
        vecs[11] = mk(1,0,2'd1,0,32'h0000_7F00,0,32'h0,32'h0,1,5'd4,32'h0,4'b0,32'h0,32'h0);
        vecs[12] = mk(0,1,2'd2,0,32'h0000_3000,0,32'h0,32'h0,1,5'd5,32'h0,4'b0,32'h0,32'h0);
        vecs[13] = mk(0,1,2'd2,0,32'h0000_0000,1,32'h0,32'h0,1,5'd5,32'h0,4'b0,32'h0,32'h0);
        vecs[14] = mk(1,0,2'd2,0,32'h0000_7F24,0,32'h0,32'h0,1,5'd4,32'h0,4'b0,32'h0,32'h0);
        vecs[15] = mk(0,1,2'd1,0,32'h0000_0101,0,32'h0,32'h0,1,5'd5,32'h0,4'b0,32'h0,32'h0);
        vecs[16] = mk(0,1,2'd2,0,32'h0000_7F0C,0,32'h0,32'h0,1,5'd5,32'h0,4'b0,32'h0,32'h0);

        // Hold reset with a valid request on the inputs. Every output must stay low.
        reset = 1'b0;
        drive_req(1, 0, 2'd2, 0, 32'h0000_0006, 0, 32'h0);
        #1;
        check_output("reset stall_o", 32'(stall_o), 32'd0);
        check_output("reset exc_valid", 32'(exc_valid), 32'd0);
        check_output("reset exc_code", 32'(exc_code), 32'd0);
        check_output("reset bus_req", 32'(bus_req), 32'd0);
        check_output("reset bus_addr", bus_addr, 32'd0);
        check_output("reset bus_be", 32'(bus_be), 32'd0);
        check_output("reset bus_wdata", bus_wdata, 32'd0);
        check_output("reset rdata_o", rdata_o, 32'd0);
        check_output("reset rdata_valid", 32'(rdata_valid), 32'd0);
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Store halfword with three wait cycles. The request must stay stable while the inputs change.
        drive_req(0, 1, 2'd1, 0, 32'h0000_0102, 0, 32'h1234_ABCD);
        #1;
        check_output("sh stall accept", 32'(stall_o), 32'd1);
        tick();
        addr  = 32'h0000_0ABC;
        wdata = 32'h5555_5555;
        width = 2'd0;
        for (int w = 0; w < 3; w++) begin
            check_output($sformatf("sh w%0d bus_req", w), 32'(bus_req), 32'd1);
            check_output($sformatf("sh w%0d bus_we", w), 32'(bus_we), 32'd1);
            check_output($sformatf("sh w%0d bus_addr", w), bus_addr, 32'h0000_0100);
            check_output($sformatf("sh w%0d bus_be", w), 32'(bus_be), 32'(4'b1100));
            check_output($sformatf("sh w%0d bus_wdata", w), bus_wdata, 32'hABCD_ABCD);
            check_output($sformatf("sh w%0d stall", w), 32'(stall_o), 32'd1);
            tick();
        end
        bus_ack = 1'b1;
        #1;
        check_output("sh ack stall", 32'(stall_o), 32'd1);
        check_output("sh ack bus_be", 32'(bus_be), 32'(4'b1100));
        tick();
        bus_ack = 1'b0;
        #1;
        check_output("sh done bus_req", 32'(bus_req), 32'd0);
        check_output("sh done stall", 32'(stall_o), 32'd0);
        check_output("sh done rdata_valid", 32'(rdata_valid), 32'd0);
        check_output("sh rdata_o held", rdata_o, 32'h0000_0055);
        idle_inputs();
        tick();

        // A flush in IDLE suppresses both the exception and the request.
        drive_req(1, 0, 2'd2, 0, 32'h0000_0006, 0, 32'h0);
        flush = 1'b1;
        #1;
        check_output("idle flush exc_valid", 32'(exc_valid), 32'd0);
        check_output("idle flush stall", 32'(stall_o), 32'd0);
        tick();
        check_output("idle flush bus_req", 32'(bus_req), 32'd0);
        idle_inputs();
        tick();

        // Flush a load during BUSY. The bus acknowledges two cycles later and the result is dropped.
        drive_req(1, 0, 2'd2, 0, 32'h0000_0010, 0, 32'h0);
        tick();
        check_output("fl busy bus_req", 32'(bus_req), 32'd1);
        flush = 1'b1;
        #1;
        check_output("fl busy stall", 32'(stall_o), 32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_output("fl wait stall", 32'(stall_o), 32'd1);
        check_output("fl wait bus_req", 32'(bus_req), 32'd1);
        check_output("fl wait rdata_valid", 32'(rdata_valid), 32'd0);
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        #1;
        check_output("fl ack stall", 32'(stall_o), 32'd1);
        tick();
        bus_ack = 1'b0;
        #1;
        check_output("fl after stall", 32'(stall_o), 32'd0);
        check_output("fl after rdata_valid", 32'(rdata_valid), 32'd0);
        check_output("fl after bus_req", 32'(bus_req), 32'd0);
        check_output("fl rdata_o kept", rdata_o, 32'h0000_0055);
        drive_req(1, 0, 2'd2, 0, 32'h0000_0020, 0, 32'h0);
        #1;
        check_output("fl idle accept stall", 32'(stall_o), 32'd1);
        tick();
        check_output("fl idle accept bus_req", 32'(bus_req), 32'd1);
        bus_ack = 1'b1;
        bus_rdata = 32'h0BAD_0BAD;
        tick();
        bus_ack = 1'b0;
        #1;
        check_output("fl next rdata_valid", 32'(rdata_valid), 32'd1);
        check_output("fl next rdata_o", rdata_o, 32'h0BAD_0BAD);
        idle_inputs();
        tick();

        // Assert reset during BUSY. A late acknowledge after release must be ignored.
        drive_req(0, 1, 2'd2, 0, 32'h0000_0040, 0, 32'h7777_8888);
        tick();
        check_output("rst busy bus_req", 32'(bus_req), 32'd1);
        reset = 1'b0;
        #1;
        check_output("rst bus_req", 32'(bus_req), 32'd0);
        check_output("rst stall", 32'(stall_o), 32'd0);
        check_output("rst bus_we", 32'(bus_we), 32'd0);
        check_output("rst bus_addr", bus_addr, 32'd0);
        check_output("rst bus_be", 32'(bus_be), 32'd0);
        check_output("rst bus_wdata", bus_wdata, 32'd0);
        check_output("rst rdata_o", rdata_o, 32'd0);
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        bus_ack = 1'b0;
        check_output("late ack bus_req", 32'(bus_req), 32'd0);
        check_output("late ack stall", 32'(stall_o), 32'd0);
        check_output("late ack rdata_valid", 32'(rdata_valid), 32'd0);
        check_output("late ack rdata_o", rdata_o, 32'd0);
        idle_inputs();
        tick();
        apply_stimulus(vecs[4], 100);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter DM_END, default 32'h0000_2FFF, last valid data-memory byte address.
REQ-002 Parameter T0_BASE, default 32'h0000_7F00, timer0 base; T1_BASE, default 32'h0000_7F10, timer1 base; IG_BASE, default 32'h0000_7F20, interrupt-generator base.
REQ-003 Ports SHALL be:
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 in_valid  in  1  M-stage holds a live instruction.
 ld / st  in  1 / 1  instruction is load / store (never both).
 width  in  2  0 byte, 1 half, 2 word.
 sign_ext  in  1  load result sign-extended (lb/lh).
 addr  in  32  effective address (ALU result).
 dm_ov  in  1  address-calculation overflow flag from ALU.
 wdata  in  32  store data (rt).
 flush  in  1  discard M-stage instruction.
 stall_o  out  1  hold pipeline.
 exc_valid  out  1  address exception for current instruction.
 exc_code  out  5  4 = AdEL, 5 = AdES.
 rdata_o  out  32  extended load result.
 rdata_valid  out  1  rdata_o valid, one cycle.
 bus_req  out  1  bus request.
 bus_we  out  1  bus write.
 bus_addr  out  32  word-aligned address.
 bus_be  out  4  byte enables.
 bus_wdata  out  32  lane-replicated store data.
 bus_ack  in  1  bus completes request this cycle.
 bus_rdata  in  32  read word, valid with bus_ack.

Function
REQ-004 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-005 Accept condition: state IDLE, in_valid, (ld|st), !flush, no exception.
REQ-006 Exception check (combinational, IDLE only), priority: dm_ov; misalignment (half addr[0]!=0, word addr[1:0]!=0); address outside [0,DM_END] and outside the three device windows (T0/T1 12 bytes, IG 4 bytes); device access with width!=word; store to timer offset 8.
REQ-007 On exception: exc_valid=1, exc_code=4 if ld else 5, same cycle; no bus request, stall_o=0, state stays IDLE.
REQ-008 On accept: stall_o=1 combinationally that cycle; next edge -> BUSY with bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata registered.
REQ-009 bus_addr={addr[31:2],2'b00}; bus_be: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],0}, word 4'b1111 (loads and stores).
REQ-010 bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-011 BUSY: all bus outputs held stable, stall_o=1 until bus_ack; bus_ack may arrive in the first BUSY cycle (minimum latency 2 cycles accept-to-release).
REQ-012 On bus_ack: bus_req=0 next edge; load lane selected by registered addr[1:0]/width, zero- or sign-extended into rdata_o; -> DONE.
REQ-013 DONE: stall_o=0, rdata_valid=1 only for a non-flushed load; next edge -> IDLE; no accept in DONE (same instruction still in M).
REQ-014 flush in IDLE or DONE: no request, no exception, -> IDLE.
REQ-015 flush in BUSY: transaction completes (bus_req held to bus_ack), result discarded, rdata_valid never asserted, bus_ack -> IDLE directly, stall_o=1 until bus_ack.
REQ-016 Exception outputs 0 outside IDLE; rdata_o holds last load value otherwise.

Reset
REQ-017 reset low: state IDLE; stall_o, exc_valid, exc_code, rdata_o, rdata_valid, bus_req, bus_we, bus_addr, bus_be, bus_wdata all 0, immediately and asynchronously.
REQ-018 reset mid-BUSY: bus_req drops at once; late bus_ack after release ignored.

Verification
REQ-019 lb addr=0x0000_0003, sign_ext=1, bus_rdata=0x80FF_FF00 with ack in first BUSY cycle -> bus_be=4'b1000, rdata_o=0xFFFF_FF80, rdata_valid pulse, stall 2 cycles.
REQ-020 sh addr=0x0000_0102, wdata=0x1234_ABCD, ack after 3 wait cycles -> bus_be=4'b1100, bus_wdata=0xABCD_ABCD, outputs stable throughout BUSY.
REQ-021 lw addr=0x0000_0006 -> exc_valid=1, exc_code=4, bus_req stays 0; sw addr=0x0000_7F08 -> exc_code=5; lh addr=0x0000_7F00 -> exc_code=4; sw addr=0x0000_3000 -> exc_code=5.
REQ-022 sw addr=0x0000_0000 with dm_ov=1 -> exc_code=5 despite in-range, aligned address.
REQ-023 lw accepted, flush during BUSY, ack 2 cycles later -> rdata_valid never 1, stall_o drops after ack, state IDLE.
REQ-024 reset asserted during BUSY -> bus_req=0 same cycle, all outputs 0; after release, a new lw completes normally.
